// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic convolution tile.
// Holds the default result width, the tile dimensions, the result-collector
// state encoding and the raster index encoding of the four tile results.
package systolic_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  localparam int unsigned OUT_ROWS = 2;
  localparam int unsigned OUT_COLS = 2;
  localparam int unsigned NUM_RES  = OUT_ROWS * OUT_COLS;

  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } coll_state_e;

  // Raster order of the drained results
  localparam logic [IDX_W-1:0] IDX_R11 = 2'd0;
  localparam logic [IDX_W-1:0] IDX_R12 = 2'd1;
  localparam logic [IDX_W-1:0] IDX_R21 = 2'd2;
  localparam logic [IDX_W-1:0] IDX_R22 = 2'd3;

endpackage

// File: rtl/systolic_res_mux.sv
// Result capture registers with a 4:1 raster-index select.
// Optional build macro: COLLECTOR_RELU_EN -- values are treated as two's
// complement and negatives are stored as 0 at capture time.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (clears all results)
//   cap_en_i    per-result capture strobe, bit i loads pe_i[i] into r[i]
//   pe_i        live PE accumulator values, index = raster index
//   sel_i       raster index to present
//   data_c_o    selected captured result (combinational from registers)
module systolic_res_mux
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RES-1:0]             cap_en_i,
  input  logic [NUM_RES-1:0][DATA_W-1:0] pe_i,
  input  logic [IDX_W-1:0]               sel_i,
  output logic [DATA_W-1:0]              data_c_o
);

  logic [NUM_RES-1:0][DATA_W-1:0] cap_val;
  logic [NUM_RES-1:0][DATA_W-1:0] r_d;
  logic [NUM_RES-1:0][DATA_W-1:0] r_q;

  // Capture-path conditioning; ReLU sits here so it costs no cycle
  always_comb begin
    cap_val = '0;
    for (int i = 0; i < NUM_RES; i++) begin
`ifdef COLLECTOR_RELU_EN
      cap_val[i] = pe_i[i][DATA_W-1] ? '0 : pe_i[i];
`else
      cap_val[i] = pe_i[i];
`endif
    end
  end

  // Load only on the settle strobe so later PE activity cannot disturb results
  always_comb begin
    r_d = r_q;
    for (int i = 0; i < NUM_RES; i++) begin
      if (cap_en_i[i]) begin
        r_d[i] = cap_val[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  // Raster select
  always_comb begin
    data_c_o = '0;
    case (sel_i)
      IDX_R11: data_c_o = r_q[0];
      IDX_R12: data_c_o = r_q[1];
      IDX_R21: data_c_o = r_q[2];
      IDX_R22: data_c_o = r_q[3];
      default: data_c_o = '0;
    endcase
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Output-side collector for the 2x2 systolic array: follows the feed
// sequence from start_i, captures each PE on its settle cycle (removing the
// diagonal skew), drains r11,r12,r21,r22 over a valid/ready stream and
// pulses array_clr_o so the array can begin the next tile clean.
// Optional build macro: COLLECTOR_RELU_EN (ReLU at capture, see systolic_res_mux).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start_i               one-cycle pulse on the array's first feed cycle
//   pe11_i..pe22_i        live PE accumulators
//   res_data_o/res_idx_o  result word and raster index, valid with res_valid_o
//   res_ready_i           downstream accept
//   tile_done_o           pulse after r22 is accepted
//   array_clr_o           pulse to zero the array accumulators
//   busy_o                collector in WAIT or DRAIN
//   overrun_o             sticky: start_i dropped while busy
//   overrun_clr_i         clears overrun_o (a same-cycle new overrun wins)
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  parameter int unsigned CAP_BASE = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] pe11_i,
  input  logic [DATA_W-1:0] pe12_i,
  input  logic [DATA_W-1:0] pe21_i,
  input  logic [DATA_W-1:0] pe22_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic [IDX_W-1:0]  res_idx_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              tile_done_o,
  output logic              array_clr_o,
  output logic              busy_o,
  output logic              overrun_o,
  input  logic              overrun_clr_i
);

  localparam int unsigned CNT_EW = CNT_W + 1;
  // Compared against the pre-saturation increment so CAP_BASE+2 = 32 is reachable
  localparam logic [CNT_EW-1:0] CAP_R11  = CNT_EW'(CAP_BASE);
  localparam logic [CNT_EW-1:0] CAP_MID  = CNT_EW'(CAP_BASE + 1);
  localparam logic [CNT_EW-1:0] CAP_R22  = CNT_EW'(CAP_BASE + 2);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  coll_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_EW-1:0] cnt_inc;
  logic [IDX_W-1:0]  res_idx_q, res_idx_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              tile_done_q, tile_done_d;
  logic              array_clr_q, array_clr_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic [NUM_RES-1:0] cap_en;
  logic              hs;
  logic              last_hs;
  logic              start_drop;

  assign cnt_inc = {1'b0, cnt_q} + CNT_EW'(1);
  assign hs      = res_valid_q & res_ready_i;
  assign last_hs = hs & (res_idx_q == IDX_R22);
  // The only start accepted while busy is the one coinciding with the final handshake
  assign start_drop = start_i & (state_q != IDLE) & ~last_hs;

  // Next-state, capture strobes and stream control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_idx_d   = res_idx_q;
    res_valid_d = res_valid_q;
    tile_done_d = 1'b0;
    array_clr_d = 1'b0;
    overrun_d   = overrun_q;
    cap_en      = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc[CNT_W-1:0];
        if (cnt_inc == CAP_R11) begin
          cap_en[0] = 1'b1;
        end
        if (cnt_inc == CAP_MID) begin
          cap_en[1] = 1'b1;
          cap_en[2] = 1'b1;
        end
        if (cnt_inc == CAP_R22) begin
          cap_en[3]   = 1'b1;
          array_clr_d = 1'b1;
          state_d     = DRAIN;
          res_valid_d = 1'b1;
          res_idx_d   = IDX_R11;
        end
      end
      DRAIN: begin
        if (last_hs) begin
          res_valid_d = 1'b0;
          res_idx_d   = IDX_R11;
          tile_done_d = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
          if (start_i) begin
            state_d = WAIT;
            cnt_d   = CNT_ONE;
          end
        end else if (hs) begin
          res_idx_d = res_idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A new overrun event takes priority over a same-cycle clear
    if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
    if (start_drop) begin
      overrun_d = 1'b1;
    end
  end

  assign busy_d = (state_d != IDLE);

  systolic_res_mux #(
    .DATA_W (DATA_W)
  ) u_res_mux (
    .clk      (clk),
    .rst      (rst),
    .cap_en_i (cap_en),
    .pe_i     ({pe22_i, pe21_i, pe12_i, pe11_i}),
    .sel_i    (res_idx_d),
    .data_c_o (res_data_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      res_idx_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      tile_done_q <= 1'b0;
      array_clr_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_idx_q   <= res_idx_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      tile_done_q <= tile_done_d;
      array_clr_q <= array_clr_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign res_data_o  = res_data_q;
  assign res_idx_o   = res_idx_q;
  assign res_valid_o = res_valid_q;
  assign tile_done_o = tile_done_q;
  assign array_clr_o = array_clr_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector (default DATA_W=8, CAP_BASE=13).
// Edge numbering follows the start edge: after edge 14 the first result is
// valid, handshakes run at edges 15..18 with ready held high.
module tb_systolic_result_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pe11, pe12, pe21, pe22;
  logic [7:0] res_data;
  logic [1:0] res_idx;
  logic       res_valid;
  logic       res_ready;
  logic       tile_done;
  logic       array_clr;
  logic       busy;
  logic       overrun;
  logic       overrun_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_result_collector #(
    .DATA_W   (8),
    .CAP_BASE (13)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .pe11_i        (pe11),
    .pe12_i        (pe12),
    .pe21_i        (pe21),
    .pe22_i        (pe22),
    .res_data_o    (res_data),
    .res_idx_o     (res_idx),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .tile_done_o   (tile_done),
    .array_clr_o   (array_clr),
    .busy_o        (busy),
    .overrun_o     (overrun),
    .overrun_clr_i (overrun_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_pe(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    pe11 = a; pe12 = b; pe21 = c; pe22 = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({res_valid, tile_done, array_clr, busy, overrun, res_idx, res_data} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b done=%b clr=%b busy=%b ovr=%b idx=%0d data=%0h, want all 0",
               res_valid, tile_done, array_clr, busy, overrun, res_idx, res_data);
    end
    tick_n(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [4];
    exp_d = '{8'd11, 8'd12, 8'd21, 8'd22};
    set_pe(8'd11, 8'd12, 8'd21, 8'd22);
    res_ready = 1'b1;
    pulse_start();
    tick_n(13);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_wait_e13: got valid=%b busy=%b, want valid=0 busy=1", res_valid, busy);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_idx !== 2'd0 || res_data !== 8'd11 || array_clr !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_e14: got valid=%b idx=%0d data=%0d clr=%b, want 1/0/11/1",
               res_valid, res_idx, res_data, array_clr);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_idx !== 2'(i) || res_data !== exp_d[i] || array_clr !== 1'b0) begin
        errors++;
        $display("FAIL basic_word%0d: got valid=%b idx=%0d data=%0d clr=%b, want 1/%0d/%0d/0",
                 i, res_valid, res_idx, res_data, array_clr, i, exp_d[i]);
      end
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || tile_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_e18: got valid=%b done=%b busy=%b, want 0/1/0", res_valid, tile_done, busy);
    end
    tick();
    checks++;
    if (tile_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b, want 0", tile_done);
    end
  endtask

  task automatic test_skew();
    logic [7:0] exp_d [4];
    exp_d = '{8'd33, 8'd44, 8'd66, 8'd22};
    set_pe(8'd33, 8'd44, 8'd66, 8'd99);
    res_ready = 1'b1;
    pulse_start();
    tick_n(12);
    pe11 = 8'd77;
    tick();
    pe22 = 8'd22;
    tick();
    set_pe(8'd1, 8'd0, 8'd0, 8'd55);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_idx !== 2'(i) || res_data !== exp_d[i]) begin
        errors++;
        $display("FAIL skew_word%0d: got valid=%b idx=%0d data=%0d, want 1/%0d/%0d",
                 i, res_valid, res_idx, res_data, i, exp_d[i]);
      end
      tick();
    end
    checks++;
    if (tile_done !== 1'b1) begin
      errors++;
      $display("FAIL skew_done: got done=%b, want 1", tile_done);
    end
    tick();
  endtask

  task automatic test_backpressure();
    set_pe(8'd11, 8'd12, 8'd21, 8'd22);
    res_ready = 1'b1;
    pulse_start();
    tick_n(15);
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_idx !== 2'd1 || res_data !== 8'd12) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b idx=%0d data=%0d, want 1/1/12",
                 i, res_valid, res_idx, res_data);
      end
    end
    res_ready = 1'b1;
    tick();
    checks++;
    if (res_idx !== 2'd2 || res_data !== 8'd21) begin
      errors++;
      $display("FAIL bp_resume_r21: got idx=%0d data=%0d, want 2/21", res_idx, res_data);
    end
    tick();
    checks++;
    if (res_idx !== 2'd3 || res_data !== 8'd22 || tile_done !== 1'b0) begin
      errors++;
      $display("FAIL bp_r22: got idx=%0d data=%0d done=%b, want 3/22/0", res_idx, res_data, tile_done);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || tile_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: got valid=%b done=%b, want 0/1", res_valid, tile_done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [4];
    exp_d = '{8'd1, 8'd2, 8'd3, 8'd4};
    set_pe(8'd11, 8'd12, 8'd21, 8'd22);
    res_ready = 1'b1;
    pulse_start();
    tick_n(17);
    // Second start coincides with the idx-3 handshake at edge 18
    start = 1'b1;
    tick();
    start = 1'b0;
    set_pe(8'd1, 8'd2, 8'd3, 8'd4);
    checks++;
    if (tile_done !== 1'b1 || overrun !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handover: got done=%b ovr=%b busy=%b valid=%b, want 1/0/1/0",
               tile_done, overrun, busy, res_valid);
    end
    tick_n(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overrun_set: got ovr=%b, want 1", overrun);
    end
    tick();
    start = 1'b1;
    overrun_clr = 1'b1;
    tick();
    start = 1'b0;
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL b2b_clr_vs_event: got ovr=%b, want 1", overrun);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overrun_clr: got ovr=%b, want 0", overrun);
    end
    tick_n(5);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_early_valid: got valid=%b, want 0", res_valid);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_idx !== 2'(i) || res_data !== exp_d[i]) begin
        errors++;
        $display("FAIL b2b_word%0d: got valid=%b idx=%0d data=%0d, want 1/%0d/%0d",
                 i, res_valid, res_idx, res_data, i, exp_d[i]);
      end
      tick();
    end
    checks++;
    if (tile_done !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_done: got done=%b ovr=%b, want 1/0", tile_done, overrun);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_d [4];
    exp_d = '{8'd40, 8'd41, 8'd42, 8'd43};
    set_pe(8'd7, 8'd8, 8'd9, 8'd10);
    res_ready = 1'b1;
    pulse_start();
    tick_n(16);
    checks++;
    if (res_idx !== 2'd2 || res_data !== 8'd9) begin
      errors++;
      $display("FAIL rst_pre_idx2: got idx=%0d data=%0d, want 2/9", res_idx, res_data);
    end
    res_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({res_valid, tile_done, array_clr, busy, overrun, res_idx, res_data} !== 15'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got valid=%b done=%b clr=%b busy=%b ovr=%b idx=%0d data=%0h, want all 0",
               res_valid, tile_done, array_clr, busy, overrun, res_idx, res_data);
    end
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    tick_n(4);
    checks++;
    if (tile_done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: got done=%b busy=%b valid=%b, want 0/0/0", tile_done, busy, res_valid);
    end
    set_pe(8'd40, 8'd41, 8'd42, 8'd43);
    pulse_start();
    tick_n(14);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_idx !== 2'(i) || res_data !== exp_d[i]) begin
        errors++;
        $display("FAIL rst_clean_word%0d: got valid=%b idx=%0d data=%0d, want 1/%0d/%0d",
                 i, res_valid, res_idx, res_data, i, exp_d[i]);
      end
      tick();
    end
    checks++;
    if (tile_done !== 1'b1) begin
      errors++;
      $display("FAIL rst_clean_done: got done=%b, want 1", tile_done);
    end
    tick();
  endtask

  task automatic test_relu();
    logic [7:0] exp_d [4];
`ifdef COLLECTOR_RELU_EN
    exp_d = '{8'h7F, 8'h00, 8'h01, 8'h00};
`else
    exp_d = '{8'h7F, 8'hF0, 8'h01, 8'hFF};
`endif
    set_pe(8'h7F, 8'hF0, 8'h01, 8'hFF);
    res_ready = 1'b1;
    pulse_start();
    tick_n(14);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_idx !== 2'(i) || res_data !== exp_d[i]) begin
        errors++;
        $display("FAIL relu_word%0d: got valid=%b idx=%0d data=%0h, want 1/%0d/%0h",
                 i, res_valid, res_idx, res_data, i, exp_d[i]);
      end
      tick();
    end
    tick();
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    res_ready   = 1'b0;
    overrun_clr = 1'b0;
    set_pe(8'd0, 8'd0, 8'd0, 8'd0);
    test_reset();
    test_basic();
    test_skew();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_relu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
